// File: rtl/uart_rx_os.sv
`default_nettype none
// uart_rx_os: oversampling UART receiver with 3-sample majority vote and FWFT receive FIFO.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_os #(
  parameter int DATA_MAX   = 9,
  parameter int OS_RATE    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  input  logic                tick,
  input  logic [3:0]          data_len,
  input  logic                parity_en,
  input  logic [1:0]          parity_mode,
  input  logic                stop2,
  input  logic                rd,
  input  logic                ovr_clr,
  output logic [DATA_MAX-1:0] data,
  output logic                par_err,
  output logic                frame_err,
  output logic                brk,
  output logic                empty,
  output logic                overrun,
  output logic                busy
);

  localparam int CW = $clog2(OS_RATE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_MAX + 3;
  localparam logic [CW-1:0] C_S0   = CW'(OS_RATE / 2 - 1);
  localparam logic [CW-1:0] C_S1   = CW'(OS_RATE / 2);
  localparam logic [CW-1:0] C_S2   = CW'(OS_RATE / 2 + 1);
  localparam logic [CW-1:0] C_LAST = CW'(OS_RATE - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2
  } state_t;

  state_t state, state_nx;

  logic                rx_m, rx_s;
  logic [CW-1:0]       cnt;
  logic                s0, s1, maj;
  logic                sample_pt, bit_end;
  logic                armed;
  logic [3:0]          len_clamp, len_l;
  logic                par_en_l, stop2_l;
  logic [1:0]          par_mode_l;
  logic [DATA_MAX-1:0] word;
  logic [3:0]          bit_idx;
  logic                perr, ferr, par_exp;
  logic                start_det, frame_done, done_ferr, done_brk, brk_cond;
  logic                push_q;
  logic [EW-1:0]       push_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign sample_pt = tick && (cnt == C_S2);
  assign bit_end   = tick && (cnt == C_LAST);
  assign maj       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign len_clamp = (data_len < 4'd5) ? 4'd5 :
                     (data_len > 4'(DATA_MAX)) ? 4'(DATA_MAX) : data_len;

  always_comb begin
    case (par_mode_l)
      2'b11:   par_exp = ~(^word);
      2'b10:   par_exp = ^word;
      2'b01:   par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic par_rx;
  // Break: every bit from start through first stop (parity included) sampled low.
  assign brk_cond = !maj && (word == '0) && (!par_en_l || !par_rx);
`else
  assign brk_cond = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start_det  = 1'b0;
    frame_done = 1'b0;
    done_ferr  = 1'b0;
    done_brk   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick && armed && !rx_s) begin
          state_nx  = ST_START;
          start_det = 1'b1;
        end
      end
      ST_START: begin
        if (sample_pt && maj) state_nx = ST_IDLE;
        else if (bit_end)     state_nx = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && (bit_idx == len_l - 4'd1))
          state_nx = par_en_l ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: begin
        if (bit_end) state_nx = ST_STOP1;
      end
      ST_STOP1: begin
        if (sample_pt) begin
          if (brk_cond) begin
            frame_done = 1'b1;
            done_ferr  = 1'b1;
            done_brk   = 1'b1;
            state_nx   = ST_IDLE;
          end else if (!stop2_l) begin
            frame_done = 1'b1;
            done_ferr  = !maj;
            state_nx   = ST_IDLE;
          end
        end else if (bit_end) begin
          state_nx = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (sample_pt) begin
          frame_done = 1'b1;
          done_ferr  = ferr | !maj;
          state_nx   = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      armed      <= 1'b0;
      len_l      <= 4'd5;
      par_en_l   <= 1'b0;
      par_mode_l <= 2'b00;
      stop2_l    <= 1'b0;
      word       <= '0;
      bit_idx    <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      push_q     <= 1'b0;
      push_word  <= '0;
`ifdef UART_RX_BREAK_DETECT_EN
      par_rx     <= 1'b0;
`endif
    end else begin
      push_q <= frame_done;
      if (frame_done) push_word <= {done_brk, done_ferr, perr, word};

      // The detecting tick counts as sample 0 of the start bit.
      if (tick) begin
        if (start_det)          cnt <= CW'(1);
        else if (cnt == C_LAST) cnt <= '0;
        else                    cnt <= cnt + CW'(1);
        if (cnt == C_S0) s0 <= rx_s;
        if (cnt == C_S1) s1 <= rx_s;
      end

      if (state == ST_IDLE) begin
        if (tick && rx_s)   armed <= 1'b1;
        else if (start_det) armed <= 1'b0;
      end else if (state_nx == ST_IDLE) begin
        armed <= frame_done & maj;
      end

      if (start_det) begin
        len_l      <= len_clamp;
        par_en_l   <= parity_en;
        par_mode_l <= parity_mode;
        stop2_l    <= stop2;
        word       <= '0;
        bit_idx    <= '0;
        perr       <= 1'b0;
        ferr       <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        par_rx     <= 1'b0;
`endif
      end

      if (state == ST_DATA) begin
        if (sample_pt) begin
          for (int i = 0; i < DATA_MAX; i++)
            if (bit_idx == 4'(i)) word[i] <= maj;
        end
        if (bit_end) bit_idx <= bit_idx + 4'd1;
      end

      if (state == ST_PARITY && sample_pt) begin
        perr <= (maj != par_exp);
`ifdef UART_RX_BREAK_DETECT_EN
        par_rx <= maj;
`endif
      end

      if (state == ST_STOP1 && sample_pt) ferr <= !maj;
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_full, do_pop, do_push;
  logic [EW-1:0] head;

  assign empty     = (wr_ptr == rd_ptr);
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop    = rd && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push   = push_q && (!fifo_full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_q && fifo_full && !do_pop) overrun <= 1'b1;
      else if (ovr_clr)                   overrun <= 1'b0;
    end
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign {brk, frame_err, par_err, data} = head;
  assign busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// tb_uart_rx_os: directed + randomized frames checked against a frame-level reference model.
module tb_uart_rx_os;
  localparam int DATA_MAX   = 9;
  localparam int OS_RATE    = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int TDIV       = 3;
  localparam int BITCLK     = OS_RATE * TDIV;
`ifdef UART_RX_BREAK_DETECT_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                rx = 1'b1;
  logic                tick = 1'b0;
  logic [3:0]          data_len = 4'd8;
  logic                parity_en = 1'b0;
  logic [1:0]          parity_mode = 2'b00;
  logic                stop2 = 1'b0;
  logic                rd = 1'b0;
  logic                ovr_clr = 1'b0;
  logic [DATA_MAX-1:0] data;
  logic                par_err, frame_err, brk, empty, overrun, busy;

  uart_rx_os #(.DATA_MAX(DATA_MAX), .OS_RATE(OS_RATE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tick(tick), .data_len(data_len),
    .parity_en(parity_en), .parity_mode(parity_mode), .stop2(stop2),
    .rd(rd), .ovr_clr(ovr_clr), .data(data), .par_err(par_err),
    .frame_err(frame_err), .brk(brk), .empty(empty), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int tdiv_cnt = 0;
  always @(negedge clk) begin
    tick = (tdiv_cnt == 0);
    tdiv_cnt = (tdiv_cnt == TDIV - 1) ? 0 : tdiv_cnt + 1;
  end

  typedef struct packed {
    logic [DATA_MAX-1:0] d;
    logic pe;
    logic fe;
    logic bk;
  } exp_t;

  exp_t q[$];
  logic exp_ovr = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic bit_time(input logic b);
    rx = b;
    repeat (BITCLK) @(negedge clk);
  endtask

  // Builds the serial frame from the arguments and records what the receiver must report.
  task automatic send_frame(input logic [3:0] dl, input logic pen, input logic [1:0] pm,
                            input logic s2, input logic [DATA_MAX-1:0] d, input logic flip,
                            input logic sb1, input logic sb2, input logic scramble,
                            input int tail_low);
    int len, ones;
    logic [DATA_MAX-1:0] dm;
    logic p, pexp;
    exp_t e;
    len  = (dl < 5) ? 5 : ((dl > DATA_MAX) ? DATA_MAX : int'(dl));
    dm   = '0;
    for (int i = 0; i < len; i++) dm[i] = d[i];
    ones = $countones(dm);
    case (pm)
      2'b11:   pexp = (ones % 2 == 0);
      2'b10:   pexp = (ones % 2 == 1);
      2'b01:   pexp = 1'b1;
      default: pexp = 1'b0;
    endcase
    p    = pexp ^ flip;
    e.d  = dm;
    e.pe = pen && (p != pexp);
    e.bk = BRK_EN && (dm == '0) && (!pen || !p) && !sb1;
    e.fe = e.bk || !sb1 || (s2 && !sb2);
    data_len = dl; parity_en = pen; parity_mode = pm; stop2 = s2;
    bit_time(1'b0);
    if (scramble) begin
      data_len    = 4'($urandom_range(0, 15));
      parity_en   = 1'($urandom_range(0, 1));
      parity_mode = 2'($urandom_range(0, 3));
      stop2       = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < len; i++) bit_time(dm[i]);
    if (pen) bit_time(p);
    bit_time(sb1);
    if (s2) bit_time(sb2);
    for (int i = 0; i < tail_low; i++) bit_time(1'b0);
    if (q.size() == FIFO_DEPTH) exp_ovr = 1'b1;
    else q.push_back(e);
    rx = 1'b1;
    repeat (2 * BITCLK) @(negedge clk);
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk("head_empty", 32'(empty), 32'd0);
      chk("data", 32'(data), 32'(e.d));
      chk("par_err", 32'(par_err), 32'(e.pe));
      chk("frame_err", 32'(frame_err), 32'(e.fe));
      chk("brk", 32'(brk), 32'(e.bk));
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
    end
    chk("drained_empty", 32'(empty), 32'd1);
    chk("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  initial begin
    #10 rst = 1'b0;
    @(negedge clk);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_par_err", 32'(par_err), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_brk", 32'(brk), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2 * BITCLK) @(negedge clk);

    // 9-bit even parity, correct then inverted parity bit
    send_frame(4'd9, 1'b1, 2'b10, 1'b0, 9'h195, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    drain();
    send_frame(4'd9, 1'b1, 2'b10, 1'b0, 9'h195, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    drain();

    // glitch shorter than half a bit
    rx = 1'b0;
    repeat (OS_RATE / 4 * TDIV) @(negedge clk);
    rx = 1'b1;
    chk("glitch_busy_rise", 32'(busy), 32'd1);
    repeat (BITCLK) @(negedge clk);
    chk("glitch_busy_fall", 32'(busy), 32'd0);
    chk("glitch_empty", 32'(empty), 32'd1);
    repeat (BITCLK) @(negedge clk);

    // 5-bit word, two stop bits
    send_frame(4'd5, 1'b0, 2'b00, 1'b1, 9'h015, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    drain();

    // framing error on second stop; line held low must not start a frame
    send_frame(4'd8, 1'b0, 2'b00, 1'b1, 9'h0A5, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    send_frame(4'd8, 1'b0, 2'b00, 1'b0, 9'h03C, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    drain();

    // overflow the FIFO
    for (int v = 1; v <= 5; v++)
      send_frame(4'd8, 1'b0, 2'b00, 1'b0, 9'(v), 1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("overrun_set", 32'(overrun), 32'd1);
    drain();
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    exp_ovr = 1'b0;
    chk("overrun_clr", 32'(overrun), 32'd0);

    // line low for 12 bit times
    send_frame(4'd8, 1'b0, 2'b00, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    drain();

    // randomized frames, config scrambled after the start bit
    for (int n = 0; n < 10; n++) begin
      int k;
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++)
        send_frame(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   9'($urandom), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 5) != 0), 1'b1, 0);
      drain();
    end

    // reset in the middle of the data bits
    data_len = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    chk("midframe_busy", 32'(busy), 32'd1);
    rx  = 1'b1;
    rst = 1'b1;
    #10 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (2 * BITCLK) @(negedge clk);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_busy_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver: the parametrised successor to the single-sample receiver. It takes a sample-rate enable from the baud generator (`OS_RATE` pulses per bit) and validates the start bit. Each bit is recovered by a 3-sample majority vote, with 5..`DATA_MAX` data bits, optional parity, and 1 or 2 stop bits. Received words and per-word error flags are buffered in a small first-word-fall-through FIFO between the serial line and the host logic.

## Interface
- `DATA_MAX`, 9: widest supported word; `data` width.
- `OS_RATE`, 16: `tick` pulses per bit period; even, >= 8.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, >= 2.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `rx`  in  1  serial line, asynchronous; idle high.
- `tick`  in  1  single-cycle oversample enable from baud generator.
- `data_len`  in  4  data bits per frame; <5 → 5, >`DATA_MAX` → `DATA_MAX`.
- `parity_en`  in  1  parity bit present.
- `parity_mode`  in  2  11 odd, 10 even, 01 mark (1), 00 space (0).
- `stop2`  in  1  two stop bits expected.
- `rd`  in  1  pop FIFO head; ignored when `empty`.
- `ovr_clr`  in  1  clear sticky `overrun`.
- `data`  out  `DATA_MAX`  FIFO head word, LSB-aligned, zero-extended.
- `par_err`  out  1  head word parity mismatch.
- `frame_err`  out  1  head word had a stop bit sampled 0.
- `brk`  out  1  head word is a break.
- `empty`  out  1  FIFO empty.
- `overrun`  out  1  sticky: a completed frame was dropped because the FIFO was full.
- `busy`  out  1  frame reception in progress (state != IDLE).

## Operation
- `rx` passes through a 2-flop synchroniser; all line logic uses the synchronised value.
- The sample counter runs on `tick` only and counts 0..`OS_RATE`-1 per bit. The bit value is the majority of the samples at counts `OS_RATE`/2-1, `OS_RATE`/2 and `OS_RATE`/2+1.
- State machine: IDLE → START → DATA → [PARITY] → STOP1 → [STOP2] → IDLE.
- IDLE:
  - Armed only after one high sample on `tick`.
  - An armed falling edge (low sample on `tick`) → START, with the counter reset to 1.
  - `data_len`, `parity_en`, `parity_mode` and `stop2` are latched on this transition. Changes mid-frame are ignored.
- START: if the majority is 1, the start is false → IDLE (not armed until a high sample is seen). Otherwise → DATA at the end of the bit.
- DATA: shifts bits LSB first; after the latched length → PARITY if enabled, else STOP1.
- PARITY: compares the received bit with the expected one. Even/odd parity is computed over the data bits; mark expects 1, space expects 0. Mismatch sets `par_err` for the word.
- STOP1/STOP2: a 0 majority sets `frame_err`. STOP2 is skipped when latched `stop2`=0.
- Frame completion: at the last stop bit's final sample, the word plus flags are pushed, then → IDLE. IDLE re-arms immediately if the stop sample was 1. After a framing error, IDLE waits for a high sample before re-arming.
- FIFO:
  - Holds {`brk`, `frame_err`, `par_err`, `data`}; outputs always show the head (zeros when empty).
  - Push when full → word dropped, `overrun`←1.
  - Push and `rd` in the same cycle when full → both succeed, no overrun.
  - `ovr_clr` clears `overrun`; if it coincides with a new overrun, set wins.

## Timing
- Reset values: `data`=0, `par_err`=`frame_err`=`brk`=0, `empty`=1, `overrun`=0, `busy`=0; FIFO pointers 0, state IDLE, not armed.
- Reset mid-frame aborts the frame with no push.
- `busy` rises the cycle after the armed falling-edge `tick`.
- Push occurs the cycle after the final stop-sample `tick`; `empty` falls and head outputs are valid on the following cycle.
- `rd` takes effect on the next edge: head advances, or `empty`↑ if that was the last entry.
- Line-to-decision latency: 2 clk synchroniser plus the sampling above.
- `tick` wider than one cycle is illegal; behaviour is undefined.

## Configuration
- `UART_RX_BREAK_DETECT_EN` defined:
  - A frame with all data bits 0, parity bit 0 (if enabled) and first stop bit 0 is pushed with `brk`=1 and `frame_err`=1.
  - The receiver then holds in IDLE, unarmed, until `rx` is seen high.
- Undefined: `brk` is constant 0; such frames are reported only as `frame_err`=1.

## Test plan
- Reset values: `rst` pulse for 10 ns → all outputs at reset values; the FIFO flag `empty`=1.
- 9-bit frame: `data_len`=9, even parity, 0x195 sent with a correct parity bit → `data`=0x195, `par_err`=0. Repeat with the parity bit inverted → `par_err`=1.
- Glitch and short words:
  - `rx` low for `OS_RATE`/4 ticks → false start; `busy` returns to 0 and nothing is pushed.
  - 5-bit word 0x15 with 2 stop bits → `data`=0x015.
- Framing error: `stop2`=1, second stop bit driven 0 → `frame_err`=1. The next frame is received correctly only after the line returns high.
- FIFO and overrun with `FIFO_DEPTH`=4:
  - Send 5 frames (0x01..0x05) without `rd` → 4 entries, `overrun`=1.
  - Pops return 0x01..0x04; `ovr_clr` → `overrun`=0.
- Break and reset mid-frame:
  - With `UART_RX_BREAK_DETECT_EN`, hold `rx` low for 12 bit times → one entry with `brk`=1 and `frame_err`=1, then no further push until `rx` goes high.
  - `rst` asserted mid-DATA → no push, `busy`=0.
